// File: rtl/regfile_2w2r_param.sv
// rtl/regfile_2w2r_param.sv - parametrised 2-write/2-read register file with valid bits and clear sweep
module regfile_2w2r_param #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WE1,
  input  logic             WE2,
  input  logic [AW-1:0]    WA1,
  input  logic [AW-1:0]    WA2,
  input  logic [WIDTH-1:0] DATA_IN1,
  input  logic [WIDTH-1:0] DATA_IN2,
  input  logic             REA1,
  input  logic             REA2,
  input  logic [AW-1:0]    RAA1,
  input  logic [AW-1:0]    RAA2,
  output logic [WIDTH-1:0] RDA1,
  output logic [WIDTH-1:0] RDA2,
  output logic             RDV1,
  output logic             RDV2,
  input  logic             CLR,
  output logic             BUSY
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             vld_q [DEPTH];
  logic             vld_d [DEPTH];
  logic             wa1_ok, wa2_ok, ra1_ok, ra2_ok;
  logic [WIDTH-1:0] rd1_d, rd2_d;
  logic             rv1_d, rv2_d;

  // Addresses beyond DEPTH exist when DEPTH is not a power of two
  assign wa1_ok = int'(WA1) < DEPTH;
  assign wa2_ok = int'(WA2) < DEPTH;
  assign ra1_ok = int'(RAA1) < DEPTH;
  assign ra2_ok = int'(RAA2) < DEPTH;

  assign BUSY = (state_q == SWEEP);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (CLR) begin
        state_d = SWEEP;
        ptr_d   = '0;
      end
    end else begin
      if (CLR) begin
        ptr_d = '0;
      end else if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = IDLE;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
  end

  // Clear first, then port 1, then port 2: later assignments win
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (state_q == SWEEP) begin
      mem_d[ptr_q] = '0;
      vld_d[ptr_q] = 1'b0;
    end
    if (WE1 && wa1_ok) begin
      mem_d[WA1] = DATA_IN1;
      vld_d[WA1] = 1'b1;
    end
    if (WE2 && wa2_ok) begin
      mem_d[WA2] = DATA_IN2;
      vld_d[WA2] = 1'b1;
    end
  end

  always_comb begin
    rd1_d = '0;
    rv1_d = 1'b0;
    rd2_d = '0;
    rv2_d = 1'b0;
    if (ra1_ok) begin
      rd1_d = BYPASS ? mem_d[RAA1] : mem_q[RAA1];
      rv1_d = BYPASS ? vld_d[RAA1] : vld_q[RAA1];
    end
    if (ra2_ok) begin
      rd2_d = BYPASS ? mem_d[RAA2] : mem_q[RAA2];
      rv2_d = BYPASS ? vld_d[RAA2] : vld_q[RAA2];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
        vld_q[i] <= vld_d[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RDA1 <= '0;
      RDV1 <= 1'b0;
      RDA2 <= '0;
      RDV2 <= 1'b0;
    end else begin
      if (REA1) begin
        RDA1 <= rd1_d;
        RDV1 <= rv1_d;
      end
      if (REA2) begin
        RDA2 <= rd2_d;
        RDV2 <= rv2_d;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2w2r_param.sv
// tb/tb_regfile_2w2r_param.sv - self-checking bench for regfile_2w2r_param (three configurations)
module tb_regfile_2w2r_param;

  logic        CLK;
  logic        RST_N;
  logic        WE1, WE2, REA1, REA2, CLR;
  logic [1:0]  WA1, WA2, RAA1, RAA2;
  logic [15:0] DATA_IN1, DATA_IN2;
  logic [15:0] rda1 [3];
  logic [15:0] rda2 [3];
  logic        rdv1 [3];
  logic        rdv2 [3];
  logic [2:0]  busy;

  int n_cmp = 0;
  int n_bad = 0;

  // instance configurations: 0 = bypass depth 4, 1 = read-first depth 4, 2 = bypass depth 3
  int cfg_depth [3] = '{4, 4, 3};
  bit cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};

  logic [15:0] m_mem  [3][4];
  bit          m_vld  [3][4];
  logic [15:0] m_rda1 [3];
  logic [15:0] m_rda2 [3];
  bit          m_rdv1 [3];
  bit          m_rdv2 [3];
  bit          m_busy [3];
  int          m_ptr  [3];
  int          bcnt   [3];

  regfile_2w2r_param #(.WIDTH(16), .DEPTH(4), .BYPASS(1'b1)) u_byp (
    .CLK(CLK), .RST_N(RST_N), .WE1(WE1), .WE2(WE2), .WA1(WA1), .WA2(WA2),
    .DATA_IN1(DATA_IN1), .DATA_IN2(DATA_IN2), .REA1(REA1), .REA2(REA2),
    .RAA1(RAA1), .RAA2(RAA2), .RDA1(rda1[0]), .RDA2(rda2[0]),
    .RDV1(rdv1[0]), .RDV2(rdv2[0]), .CLR(CLR), .BUSY(busy[0]));

  regfile_2w2r_param #(.WIDTH(16), .DEPTH(4), .BYPASS(1'b0)) u_nobyp (
    .CLK(CLK), .RST_N(RST_N), .WE1(WE1), .WE2(WE2), .WA1(WA1), .WA2(WA2),
    .DATA_IN1(DATA_IN1), .DATA_IN2(DATA_IN2), .REA1(REA1), .REA2(REA2),
    .RAA1(RAA1), .RAA2(RAA2), .RDA1(rda1[1]), .RDA2(rda2[1]),
    .RDV1(rdv1[1]), .RDV2(rdv2[1]), .CLR(CLR), .BUSY(busy[1]));

  regfile_2w2r_param #(.WIDTH(16), .DEPTH(3), .BYPASS(1'b1)) u_d3 (
    .CLK(CLK), .RST_N(RST_N), .WE1(WE1), .WE2(WE2), .WA1(WA1), .WA2(WA2),
    .DATA_IN1(DATA_IN1), .DATA_IN2(DATA_IN2), .REA1(REA1), .REA2(REA2),
    .RAA1(RAA1), .RAA2(RAA2), .RDA1(rda1[2]), .RDA2(rda2[2]),
    .RDV1(rdv1[2]), .RDV2(rdv2[2]), .CLR(CLR), .BUSY(busy[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_mem[k][i] = '0;
        m_vld[k][i] = 1'b0;
      end
      m_rda1[k] = '0; m_rda2[k] = '0;
      m_rdv1[k] = 1'b0; m_rdv2[k] = 1'b0;
      m_busy[k] = 1'b0; m_ptr[k] = 0;
    end
  endtask

  // One clock edge of the reference: compute the post-edge array, then reads, then sweep progress
  task automatic model_edge();
    if (!RST_N) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        int          d;
        logic [15:0] nm [4];
        bit          nv [4];
        d = cfg_depth[k];
        for (int i = 0; i < 4; i++) begin
          nm[i] = m_mem[k][i];
          nv[i] = m_vld[k][i];
        end
        if (m_busy[k]) begin
          nm[m_ptr[k]] = '0;
          nv[m_ptr[k]] = 1'b0;
        end
        if (WE1 && int'(WA1) < d) begin nm[WA1] = DATA_IN1; nv[WA1] = 1'b1; end
        if (WE2 && int'(WA2) < d) begin nm[WA2] = DATA_IN2; nv[WA2] = 1'b1; end
        if (REA1) begin
          if (int'(RAA1) >= d) begin m_rda1[k] = '0; m_rdv1[k] = 1'b0; end
          else if (cfg_byp[k]) begin m_rda1[k] = nm[RAA1]; m_rdv1[k] = nv[RAA1]; end
          else begin m_rda1[k] = m_mem[k][RAA1]; m_rdv1[k] = m_vld[k][RAA1]; end
        end
        if (REA2) begin
          if (int'(RAA2) >= d) begin m_rda2[k] = '0; m_rdv2[k] = 1'b0; end
          else if (cfg_byp[k]) begin m_rda2[k] = nm[RAA2]; m_rdv2[k] = nv[RAA2]; end
          else begin m_rda2[k] = m_mem[k][RAA2]; m_rdv2[k] = m_vld[k][RAA2]; end
        end
        if (CLR) begin
          m_busy[k] = 1'b1; m_ptr[k] = 0;
        end else if (m_busy[k]) begin
          if (m_ptr[k] == d - 1) begin m_busy[k] = 1'b0; m_ptr[k] = 0; end
          else m_ptr[k] = m_ptr[k] + 1;
        end
        for (int i = 0; i < 4; i++) begin
          m_mem[k][i] = nm[i];
          m_vld[k][i] = nv[i];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("i%0d RDA1", k), 32'(rda1[k]), 32'(m_rda1[k]));
      chk($sformatf("i%0d RDV1", k), 32'(rdv1[k]), 32'(m_rdv1[k]));
      chk($sformatf("i%0d RDA2", k), 32'(rda2[k]), 32'(m_rda2[k]));
      chk($sformatf("i%0d RDV2", k), 32'(rdv2[k]), 32'(m_rdv2[k]));
      chk($sformatf("i%0d BUSY", k), 32'(busy[k]), 32'(m_busy[k]));
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    WE1 = 1'b0; WE2 = 1'b0; REA1 = 1'b0; REA2 = 1'b0; CLR = 1'b0;
    WA1 = '0; WA2 = '0; RAA1 = '0; RAA2 = '0; DATA_IN1 = '0; DATA_IN2 = '0;
  endtask

  task automatic fill(input logic [15:0] base);
    WE1 = 1'b1; WE2 = 1'b1;
    WA1 = 2'd0; DATA_IN1 = base;         WA2 = 2'd1; DATA_IN2 = base + 16'd1;
    cyc();
    WA1 = 2'd2; DATA_IN1 = base + 16'd2; WA2 = 2'd3; DATA_IN2 = base + 16'd3;
    cyc();
    WE1 = 1'b0; WE2 = 1'b0;
  endtask

  // Counts BUSY-high cycles starting with the edge that sampled CLR
  task automatic pulse_and_count();
    CLR = 1'b1;
    cyc();
    CLR = 1'b0;
    for (int k = 0; k < 3; k++) bcnt[k] = busy[k] ? 1 : 0;
    for (int n = 0; n < 8; n++) begin
      cyc();
      for (int k = 0; k < 3; k++) if (busy[k]) bcnt[k]++;
    end
  endtask

  typedef struct {
    bit        we1; bit [1:0] wa1; bit [15:0] d1;
    bit        we2; bit [1:0] wa2; bit [15:0] d2;
    bit        rea1; bit [1:0] raa1; bit rea2; bit [1:0] raa2;
    bit [15:0] e_rda1; bit e_rdv1; bit [15:0] e_rda2; bit e_rdv2;
    bit [15:0] n_rda2; bit [15:0] t_rda2; bit t_rdv2;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd2,1'b0,2'd0, 16'h0000,1'b0,16'h0000,1'b0, 16'h0000, 16'h0000,1'b0};
    vecs[1] = '{1'b1,2'd2,16'h1234, 1'b0,2'd0,16'h0000, 1'b0,2'd0,1'b0,2'd0, 16'h0000,1'b0,16'h0000,1'b0, 16'h0000, 16'h0000,1'b0};
    vecs[2] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd2,1'b0,2'd0, 16'h1234,1'b1,16'h0000,1'b0, 16'h0000, 16'h0000,1'b0};
    vecs[3] = '{1'b1,2'd1,16'hAAAA, 1'b1,2'd1,16'h5555, 1'b0,2'd0,1'b0,2'd0, 16'h1234,1'b1,16'h0000,1'b0, 16'h0000, 16'h0000,1'b0};
    vecs[4] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd1,1'b0,2'd0, 16'h5555,1'b1,16'h0000,1'b0, 16'h0000, 16'h0000,1'b0};
    vecs[5] = '{1'b1,2'd3,16'h0001, 1'b0,2'd0,16'h0000, 1'b0,2'd0,1'b0,2'd0, 16'h5555,1'b1,16'h0000,1'b0, 16'h0000, 16'h0000,1'b0};
    vecs[6] = '{1'b0,2'd0,16'h0000, 1'b1,2'd3,16'hBEEF, 1'b0,2'd0,1'b1,2'd3, 16'h5555,1'b1,16'hBEEF,1'b1, 16'h0001, 16'h0000,1'b0};
    vecs[7] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0,1'b1,2'd3, 16'h5555,1'b1,16'hBEEF,1'b1, 16'hBEEF, 16'h0000,1'b0};
    vecs[8] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0,1'b1,2'd2, 16'h5555,1'b1,16'h1234,1'b1, 16'h1234, 16'h1234,1'b1};

    RST_N = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) cyc();
    RST_N = 1'b1;

    for (int v = 0; v < 9; v++) begin
      WE1 = vecs[v].we1; WA1 = vecs[v].wa1; DATA_IN1 = vecs[v].d1;
      WE2 = vecs[v].we2; WA2 = vecs[v].wa2; DATA_IN2 = vecs[v].d2;
      REA1 = vecs[v].rea1; RAA1 = vecs[v].raa1; REA2 = vecs[v].rea2; RAA2 = vecs[v].raa2;
      cyc();
      chk($sformatf("vec%0d RDA1", v), 32'(rda1[0]), 32'(vecs[v].e_rda1));
      chk($sformatf("vec%0d RDV1", v), 32'(rdv1[0]), 32'(vecs[v].e_rdv1));
      chk($sformatf("vec%0d RDA2", v), 32'(rda2[0]), 32'(vecs[v].e_rda2));
      chk($sformatf("vec%0d RDV2", v), 32'(rdv2[0]), 32'(vecs[v].e_rdv2));
      chk($sformatf("vec%0d nobyp RDA2", v), 32'(rda2[1]), 32'(vecs[v].n_rda2));
      chk($sformatf("vec%0d d3 RDA2", v), 32'(rda2[2]), 32'(vecs[v].t_rda2));
      chk($sformatf("vec%0d d3 RDV2", v), 32'(rdv2[2]), 32'(vecs[v].t_rdv2));
    end
    idle_inputs();

    fill(16'h1000);
    pulse_and_count();
    chk("sweep busy d4", 32'(bcnt[0]), 32'd4);
    chk("sweep busy d4 nobyp", 32'(bcnt[1]), 32'd4);
    chk("sweep busy d3", 32'(bcnt[2]), 32'd3);
    for (int a = 0; a < 4; a++) begin
      REA1 = 1'b1; RAA1 = 2'(a);
      cyc();
      chk($sformatf("cleared e%0d RDA1", a), 32'(rda1[0]), 32'd0);
      chk($sformatf("cleared e%0d RDV1", a), 32'(rdv1[0]), 32'd0);
    end
    REA1 = 1'b0;

    fill(16'h2000);
    CLR = 1'b1;
    cyc();
    CLR = 1'b0;
    cyc();
    cyc();
    WE1 = 1'b1; WA1 = 2'd2; DATA_IN1 = 16'h7777;
    cyc();
    WE1 = 1'b0;
    repeat (3) cyc();
    REA1 = 1'b1; RAA1 = 2'd2; REA2 = 1'b1; RAA2 = 2'd1;
    cyc();
    chk("ptr write RDA1", 32'(rda1[0]), 32'h7777);
    chk("ptr write RDV1", 32'(rdv1[0]), 32'd1);
    chk("ptr write d3 RDA1", 32'(rda1[2]), 32'h7777);
    chk("ptr neighbour RDV2", 32'(rdv2[0]), 32'd0);
    REA1 = 1'b0; REA2 = 1'b0;

    fill(16'h3000);
    CLR = 1'b1;
    cyc();
    CLR = 1'b0;
    cyc();
    pulse_and_count();
    chk("restart busy d4", 32'(bcnt[0]), 32'd4);
    chk("restart busy d3", 32'(bcnt[2]), 32'd3);

    WE1 = 1'b1; WA1 = 2'd0; DATA_IN1 = 16'hABCD;
    cyc();
    WE1 = 1'b0; REA1 = 1'b1; RAA1 = 2'd0;
    cyc();
    REA1 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      WE1 = 1'b1; WA1 = 2'd0; DATA_IN1 = 16'(16'h0100 + n);
      cyc();
      chk($sformatf("hold %0d RDA1", n), 32'(rda1[0]), 32'hABCD);
    end
    WE1 = 1'b0;

    fill(16'h4000);
    REA1 = 1'b1; RAA1 = 2'd1; REA2 = 1'b1; RAA2 = 2'd2;
    CLR = 1'b1;
    cyc();
    CLR = 1'b0;
    cyc();
    #3;
    RST_N = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async i%0d RDA1", k), 32'(rda1[k]), 32'd0);
      chk($sformatf("async i%0d RDV1", k), 32'(rdv1[k]), 32'd0);
      chk($sformatf("async i%0d RDA2", k), 32'(rda2[k]), 32'd0);
      chk($sformatf("async i%0d BUSY", k), 32'(busy[k]), 32'd0);
    end
    cyc();
    RST_N = 1'b1;
    cyc();
    chk("post reset RDV1", 32'(rdv1[0]), 32'd0);
    idle_inputs();

    for (int n = 0; n < 400; n++) begin
      WE1 = 1'($urandom_range(0, 1)); WA1 = 2'($urandom_range(0, 3)); DATA_IN1 = 16'($urandom);
      WE2 = 1'($urandom_range(0, 1)); WA2 = 2'($urandom_range(0, 3)); DATA_IN2 = 16'($urandom);
      REA1 = 1'($urandom_range(0, 1)); RAA1 = 2'($urandom_range(0, 3));
      REA2 = 1'($urandom_range(0, 1)); RAA2 = 2'($urandom_range(0, 3));
      CLR = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r_param.md
# regfile_2w2r_param

Parametrised two-write/two-read register file for the factorial datapath, replacing the fixed 2×16 file. Width and depth are configurable. Read outputs are registered, and write-port priority is defined. Each entry carries a valid bit, and a hardware clear sequencer zeroes the file one entry per cycle. It sits between the control FSM and the multiplier/counter datapath and holds operands, partial products and loop counters.

## Interface
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 4, number of entries (≥2, need not be a power of two)
- BYPASS, 1, 1 = write-first read of an entry written in the same cycle; 0 = read-first
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- WE1, WE2  in  1  write enables, ports 1/2
- WA1, WA2  in  AW  write addresses
- DATA_IN1, DATA_IN2  in  WIDTH  write data
- REA1, REA2  in  1  read enables, ports 1/2
- RAA1, RAA2  in  AW  read addresses
- RDA1, RDA2  out  WIDTH  registered read data
- RDV1, RDV2  out  1  registered valid flag of the entry read
- CLR  in  1  start clear sweep (sampled each cycle)
- BUSY  out  1  clear sweep in progress

## Operation
- Storage: DEPTH × WIDTH data array plus DEPTH valid bits.
- Write: when WEn=1 and WAn<DEPTH, mem[WAn]←DATA_INn and valid[WAn]←1 at the clock edge. Addresses ≥DEPTH are ignored silently.
- Write conflict: WE1=WE2=1 with WA1=WA2 → port 2 wins. Valid is set once.
- Read: when REAn=1 at a clock edge, RDAn←mem[RAAn] and RDVn←valid[RAAn].
  - When REAn=0, RDAn and RDVn hold their previous values. Outputs are never Z.
  - Address ≥DEPTH → RDAn←0, RDVn←0.
- Read-during-write to the same address:
  - BYPASS=1: the registered output takes the winning write data, with RDV=1.
  - BYPASS=0: the registered output takes the pre-write contents.
- Clear sweep FSM with states IDLE and SWEEP, and an AW-bit pointer PTR:
  - IDLE: CLR=1 → SWEEP, PTR←0, BUSY←1.
  - SWEEP: each cycle, mem[PTR]←0, valid[PTR]←0, PTR←PTR+1. After the cycle clearing entry DEPTH−1 → IDLE, BUSY←0.
  - CLR=1 while in SWEEP restarts the sweep with PTR←0. Entries already cleared stay cleared.
  - A normal write to entry PTR in the same cycle wins over the clear: data is written and valid←1.
  - Writes to other entries proceed normally during the sweep. Reads are allowed during the sweep and see the array state before that edge, subject to the BYPASS rule, which also applies to the clear (clear treated as a write of 0 with valid 0).
- Reset (RST_N=0, asynchronous): all mem←0, all valid←0, RDA1/RDA2←0, RDV1/RDV2←0, BUSY←0, state IDLE, PTR←0. Reset mid-sweep aborts the sweep immediately.

## Timing
- Write latency: 1 cycle. Data is visible to a read issued on the next edge.
- Read latency: 1 cycle. RDA/RDV are valid after the edge that sampled REA.
- Clear: CLR sampled at edge t → BUSY high from t until edge t+DEPTH, where BUSY falls. Entry i is cleared at edge t+1+i.
- BUSY and RDV are registered outputs; no combinational input-to-output paths.
- Release of RST_N is assumed synchronous to CLK.

## Test plan
- Reset/basic, WIDTH=16, DEPTH=4:
  - After reset, REA1=1 with RAA1=2 → RDA1=0, RDV1=0.
  - Write 0x1234 to entry 2, then read it → RDA1=0x1234 and RDV1=1 one cycle after the read edge.
- Write conflict: WE1=WE2=1, WA1=WA2=1, DATA_IN1=0xAAAA, DATA_IN2=0x5555 → a later read of entry 1 gives 0x5555.
- Bypass: same-cycle write 0xBEEF to entry 3 and read of entry 3, with old value 0x0001:
  - BYPASS=1 → RDA2=0xBEEF.
  - BYPASS=0 → RDA2=0x0001.
- Clear sweep:
  - Fill all 4 entries, pulse CLR → BUSY high for exactly 4 cycles, then all reads return 0 with RDV=0.
  - Write 0x7777 to entry 2 in the cycle PTR=2 → entry 2 reads 0x7777 with RDV=1.
  - CLR re-pulsed mid-sweep → BUSY extends to 4 cycles counted from the new pulse.
- Non-power-of-two, DEPTH=3:
  - Write to address 3 is ignored.
  - Read of address 3 → RDA=0, RDV=0.
  - Sweep lasts 3 cycles.
- Hold and async reset:
  - REA1=0 keeps RDA1 constant while entries change.
  - Assert RST_N low mid-sweep and mid-cycle → all outputs 0 immediately, without waiting for a CLK edge.
